conv3_stream_ctrl: RTL and testbench
====================================

CONV3_STREAM_CTRL -- requirements
Module: conv3_stream_ctrl

Interface
REQ-001 SHALL have parameter LAT, default 2, meaning datapath cycles from an enabled sample edge to its valid result.
REQ-002 SHALL have parameter FDEPTH, default 4, meaning result FIFO depth; FDEPTH >= LAT+1.
REQ-003 SHALL have port clk  in  1  single clock, rising edge; all state changes on it.
REQ-004 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  in  1  frame start request, sampled only in IDLE.
REQ-006 SHALL have port len  in  8  sample count of the frame, captured on an accepted start.
REQ-007 SHALL have port k_in  in  12  kernel set {k2,k1,k0}, captured on an accepted start.
REQ-008 SHALL have ports s_valid in 1, s_data in 4, s_ready out 1  sample input, valid/ready handshake.
REQ-009 SHALL have ports kernel_0, kernel_1, kernel_2  out  4 each  coefficients to the 3-tap datapath.
REQ-010 SHALL have port data  out  4  sample to the datapath.
REQ-011 SHALL have port dp_en  out  1  datapath shift enable; the datapath advances only when high.
REQ-012 SHALL have port result  in  10  datapath result, k0*x[n]+k1*x[n-1]+k2*x[n-2], unsigned.
REQ-013 SHALL have ports m_valid out 1, m_result out 10, m_ready in 1  result output, valid/ready handshake.
REQ-014 SHALL have ports busy out 1 (state != IDLE) and done out 1 (one-cycle end-of-frame pulse).

Function
REQ-015 SHALL implement states IDLE, LOAD, STREAM, DRAIN, DONE.
REQ-016 IDLE->LOAD on start=1; LOAD lasts exactly one cycle, in which k_in is driven onto kernel_0..2.
REQ-017 LOAD->STREAM if len>0; LOAD->DONE if len=0, with no dp_en and no results.
REQ-018 kernel_0..2 SHALL hold their values from LOAD until the next LOAD.
REQ-019 s_ready SHALL equal (state==STREAM) && (remaining>0) && (credits>0), where credits = FDEPTH - FIFO occupancy - in-flight results.
REQ-020 On an s_valid&&s_ready cycle: data=s_data, dp_en=1, remaining decrements, and a tag enters a LAT-deep valid pipeline. Otherwise dp_en=0 and data holds its last value.
REQ-021 When a tag exits the pipeline, result SHALL be pushed into the FIFO in that same cycle.
REQ-022 STREAM->DRAIN when remaining reaches 0; DRAIN->DONE when the pipeline is empty and the FIFO is empty.
REQ-023 DONE SHALL assert done for one cycle, then go to IDLE.
REQ-024 m_valid = FIFO not empty; m_result = FIFO head; pop on m_valid&&m_ready.
REQ-025 Simultaneous push and pop SHALL keep occupancy unchanged.
REQ-026 The credit rule SHALL guarantee the FIFO never overflows and no result is dropped.
REQ-027 start outside IDLE SHALL be ignored.
REQ-028 Results SHALL leave in sample order, exactly len per frame.
REQ-029 Pointers SHALL wrap modulo FDEPTH.

Reset
REQ-030 rst SHALL force IDLE immediately and clear remaining, the pipeline tags and the FIFO pointers.
REQ-031 Reset output values: kernel_0..2=0, data=0, dp_en=0, s_ready=0, m_valid=0, m_result=0, busy=0, done=0.
REQ-032 Reset mid-frame SHALL discard in-flight and buffered results, produce no done pulse, and accept a new start on the first cycle after rst falls.

Structure
REQ-033 Package conv3_pkg SHALL hold DW=4, KW=4, RW=10, LENW=8, default LAT and FDEPTH, and the state enum.
REQ-034 Sub-module conv3_res_fifo (synchronous FIFO, async reset, FDEPTH x RW, full/empty/count) SHALL hold the result buffer.

Verification
REQ-035 k_in=12'hFFF, len=3, samples 15,15,15, m_ready=1 -> third result 675, done LAT+few cycles after the last accept, 3 results total.
REQ-036 k=(k0=1,k1=2,k2=3), samples 1,2,3,4, m_ready=0 -> s_ready drops once credits reach 0 and no data is lost; after m_ready=1, results arrive in order.
REQ-037 len=0 -> LOAD, DONE, IDLE in 3 cycles; dp_en never asserts; m_valid stays 0.
REQ-038 start pulsed during STREAM -> ignored; the frame count is unchanged.
REQ-039 rst asserted mid-STREAM with the FIFO at 2 entries -> all outputs immediately at reset values; the next frame produces correct results.
REQ-040 s_valid toggled 1,0,1,0 -> dp_en mirrors accepts; data holds its value through bubbles; results unaffected.

Source files
------------

// File: rtl/conv3_pkg.sv
// Shared widths, defaults and state encoding
// for the 3-tap convolution stream controller.
package conv3_pkg;
   localparam int DW         = 4;
   localparam int KW         = 4;
   localparam int RW         = 10;
   localparam int LENW       = 8;
   localparam int LAT_DEF    = 2;
   localparam int FDEPTH_DEF = 4;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      STREAM,
      DRAIN,
      DONE
   } state_t;
endpackage

// File: rtl/conv3_res_fifo.sv
// Synchronous result FIFO with async reset,
// occupancy count and pointers wrapping at DEPTH.
module conv3_res_fifo
   import conv3_pkg::*;
#(
   parameter int DEPTH = FDEPTH_DEF,
   parameter int W     = RW,
   localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW   = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic [W-1:0]  din,
   input  logic          pop,
   output logic [W-1:0]  dout,
   output logic          full,
   output logic          empty,
   output logic [CW-1:0] count
);
   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] cnt;
   logic          do_push;
   logic          do_pop;

   function automatic logic [AW-1:0] nxt(
      input logic [AW-1:0] p
   );
      return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign empty   = (cnt == '0);
   assign full    = (cnt == CW'(DEPTH));
   assign count   = cnt;
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = empty ? '0 : mem[rd_ptr];

   // pointer and occupancy bookkeeping
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) wr_ptr <= nxt(wr_ptr);
         if (do_pop)  rd_ptr <= nxt(rd_ptr);
         unique case ({do_push, do_pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

   // storage array, contents need no reset
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end
endmodule

// File: rtl/conv3_stream_ctrl.sv
// Frame controller feeding an external 3-tap
// datapath and buffering its results with credits.
module conv3_stream_ctrl
   import conv3_pkg::*;
#(
   parameter int LAT    = LAT_DEF,
   parameter int FDEPTH = FDEPTH_DEF
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [LENW-1:0] len,
   input  logic [3*KW-1:0] k_in,
   input  logic            s_valid,
   input  logic [DW-1:0]   s_data,
   output logic            s_ready,
   output logic [KW-1:0]   kernel_0,
   output logic [KW-1:0]   kernel_1,
   output logic [KW-1:0]   kernel_2,
   output logic [DW-1:0]   data,
   output logic            dp_en,
   input  logic [RW-1:0]   result,
   output logic            m_valid,
   output logic [RW-1:0]   m_result,
   input  logic            m_ready,
   output logic            busy,
   output logic            done
);
   localparam int CW = $clog2(FDEPTH + 1);

   state_t          state;
   logic [LENW-1:0] remaining;
   logic [LAT-1:0]  pipe;
   logic [DW-1:0]   data_q;
   logic [CW-1:0]   fcount;
   logic            ffull;
   logic            fempty;
   logic [CW:0]     used;
   logic            accept;

   // slots already claimed: buffered plus in flight
   always_comb begin
      used = {1'b0, fcount};
      for (int i = 0; i < LAT; i++) begin
         used = used + {{CW{1'b0}}, pipe[i]};
      end
   end

   assign s_ready = (state == STREAM)
                 && (remaining != '0)
                 && (used < (CW + 1)'(FDEPTH))
                 && !ffull;
   assign accept  = s_valid && s_ready;
   assign dp_en   = accept;
   assign data    = accept ? s_data : data_q;
   assign m_valid = !fempty;
   assign busy    = (state != IDLE);
   assign done    = (state == DONE);

   // last accepted sample, held through bubbles
   always_ff @(posedge clk or posedge rst) begin
      if (rst) data_q <= '0;
      else if (accept) data_q <= s_data;
   end

   // tag pipeline tracking datapath latency
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pipe <= '0;
      end else begin
         pipe[0] <= accept;
         for (int i = 1; i < LAT; i++) begin
            pipe[i] <= pipe[i-1];
         end
      end
   end

   // frame sequencing, kernel and length capture
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         remaining <= '0;
         kernel_0  <= '0;
         kernel_1  <= '0;
         kernel_2  <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  state     <= LOAD;
                  remaining <= len;
                  kernel_0  <= k_in[KW-1:0];
                  kernel_1  <= k_in[2*KW-1:KW];
                  kernel_2  <= k_in[3*KW-1:2*KW];
               end
            end
            LOAD: begin
               state <= (remaining != '0) ? STREAM : DONE;
            end
            STREAM: begin
               if (accept) begin
                  remaining <= remaining - 1'b1;
                  if (remaining == LENW'(1)) state <= DRAIN;
               end
            end
            DRAIN: begin
               if (pipe == '0 && fempty) state <= DONE;
            end
            DONE: begin
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   conv3_res_fifo #(
      .DEPTH (FDEPTH),
      .W     (RW)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (pipe[LAT-1]),
      .din   (result),
      .pop   (m_ready),
      .dout  (m_result),
      .full  (ffull),
      .empty (fempty),
      .count (fcount)
   );
endmodule

// File: tb/tb_conv3_stream_ctrl.sv
// Bench: behavioural 3-tap datapath plus
// scoreboard of expected results in sample order.
module tb_conv3_stream_ctrl;
   import conv3_pkg::*;

   localparam int LAT    = 2;
   localparam int FDEPTH = 4;

   logic        clk = 0;
   logic        rst = 1;
   logic        start = 0;
   logic [7:0]  len = 0;
   logic [11:0] k_in = 0;
   logic        s_valid = 0;
   logic [3:0]  s_data = 0;
   logic        s_ready;
   logic [3:0]  kernel_0, kernel_1, kernel_2;
   logic [3:0]  data;
   logic        dp_en;
   logic [9:0]  result;
   logic        m_valid;
   logic [9:0]  m_result;
   logic        m_ready = 0;
   logic        busy;
   logic        done;

   int checks = 0;
   int failures = 0;
   int q[$];
   int h0 = 0, h1 = 0, h2 = 0;
   int last_data = 0;
   int got_n = 0, done_n = 0, last_res = 0;
   int cycle = 0, last_acc = 0, done_cyc = 0;
   int rdy_mode = 0;
   int smp[16];
   int dn0;

   conv3_stream_ctrl #(.LAT(LAT), .FDEPTH(FDEPTH)) dut (
      .clk(clk), .rst(rst), .start(start), .len(len),
      .k_in(k_in), .s_valid(s_valid), .s_data(s_data),
      .s_ready(s_ready), .kernel_0(kernel_0),
      .kernel_1(kernel_1), .kernel_2(kernel_2),
      .data(data), .dp_en(dp_en), .result(result),
      .m_valid(m_valid), .m_result(m_result),
      .m_ready(m_ready), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cycle++;

   task automatic check(input string tag,
                        input int got, input int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // external datapath model: taps shift on dp_en
   logic [3:0] t0 = 0, t1 = 0, t2 = 0;
   logic [9:0] sum, dly = 0;
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         t0 <= 0; t1 <= 0; t2 <= 0;
      end else if (dp_en) begin
         t2 <= t1; t1 <= t0; t0 <= data;
      end
   end
   assign sum = {6'd0, kernel_0} * {6'd0, t0}
              + {6'd0, kernel_1} * {6'd0, t1}
              + {6'd0, kernel_2} * {6'd0, t2};
   always @(posedge clk) dly <= sum;
   assign result = dly;

   // consumer ready: 0 off, 1 on, 2 random
   always begin
      @(posedge clk); #1;
      if (rdy_mode == 2) m_ready = 1'($urandom_range(0, 1));
      else m_ready = (rdy_mode == 1);
   end

   // output monitor against scoreboard
   always @(negedge clk) begin
      int e;
      if (!rst && m_valid && m_ready) begin
         check("sb_nonempty", int'(q.size() != 0), 1);
         if (q.size() != 0) begin
            e = q.pop_front();
            check("result", int'(m_result), e);
         end
         last_res = int'(m_result);
         got_n++;
      end
      if (done) done_n++;
   end

   task automatic run_frame(input logic [11:0] k,
                            input int n, input bit tgl);
      int i = 0;
      int g = 0;
      start = 1; len = 8'(n); k_in = k; got_n = 0;
      @(posedge clk); #1; start = 0;
      @(negedge clk);
      check("busy_load", int'(busy), 1);
      check("k0_load", int'(kernel_0), int'(k[3:0]));
      check("k2_load", int'(kernel_2), int'(k[11:8]));
      @(posedge clk); #1;
      while (i < n && g < 300) begin
         s_valid = tgl ? (g % 2 == 0) : 1'b1;
         s_data = 4'(smp[i]);
         @(negedge clk);
         if (s_valid && s_ready) begin
            check("dp_en_acc", int'(dp_en), 1);
            check("data_acc", int'(data), smp[i]);
            h2 = h1; h1 = h0; h0 = smp[i];
            q.push_back(int'(k[3:0]) * h0
                      + int'(k[7:4]) * h1
                      + int'(k[11:8]) * h2);
            last_data = smp[i];
            last_acc = cycle;
            i++;
         end else begin
            check("dp_en_idle", int'(dp_en), 0);
            check("data_hold", int'(data), last_data);
         end
         @(posedge clk); #1;
         g++;
      end
      s_valid = 0;
      check("frame_fed", i, n);
   endtask

   task automatic wait_done(input int n);
      int w = 0;
      bit seen = 0;
      while (!seen && w < 300) begin
         @(negedge clk);
         w++;
         seen = done;
      end
      check("done_seen", int'(seen), 1);
      done_cyc = cycle;
      check("frame_results", got_n, n);
      @(negedge clk);
      check("done_pulse", int'(done), 0);
      check("idle_after", int'(busy), 0);
      @(posedge clk); #1;
   endtask

   task automatic check_reset_outs(input string tag);
      check({tag, "_busy"}, int'(busy), 0);
      check({tag, "_done"}, int'(done), 0);
      check({tag, "_sready"}, int'(s_ready), 0);
      check({tag, "_mvalid"}, int'(m_valid), 0);
      check({tag, "_mresult"}, int'(m_result), 0);
      check({tag, "_dpen"}, int'(dp_en), 0);
      check({tag, "_data"}, int'(data), 0);
      check({tag, "_k0"}, int'(kernel_0), 0);
      check({tag, "_k1"}, int'(kernel_1), 0);
      check({tag, "_k2"}, int'(kernel_2), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=1 exp=0");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(posedge clk);
      #1;
      check_reset_outs("rst0");
      rst = 0;
      rdy_mode = 1;
      @(posedge clk); #1;

      // saturated kernel, three max samples
      for (int i = 0; i < 3; i++) smp[i] = 15;
      run_frame(12'hFFF, 3, 0);
      wait_done(3);
      check("third_675", last_res, 675);
      check("done_lat_hi",
            int'(done_cyc - last_acc <= LAT + 4), 1);
      check("done_lat_lo",
            int'(done_cyc - last_acc >= LAT + 1), 1);

      // backpressure until credits run out
      rdy_mode = 0;
      @(posedge clk); #1;
      for (int i = 0; i < 6; i++) smp[i] = i + 1;
      fork
         run_frame({4'd3, 4'd2, 4'd1}, 6, 0);
         begin
            repeat (14) @(posedge clk);
            @(negedge clk);
            check("credit_sready", int'(s_ready), 0);
            check("credit_mvalid", int'(m_valid), 1);
            check("credit_busy", int'(busy), 1);
            rdy_mode = 1;
         end
      join
      wait_done(6);

      // empty frame
      dn0 = done_n;
      start = 1; len = 0; k_in = 12'hABC;
      @(posedge clk); #1; start = 0;
      @(negedge clk);
      check("len0_load_busy", int'(busy), 1);
      check("len0_load_k1", int'(kernel_1), 11);
      check("len0_load_done", int'(done), 0);
      @(negedge clk);
      check("len0_done", int'(done), 1);
      check("len0_dpen", int'(dp_en), 0);
      check("len0_mvalid", int'(m_valid), 0);
      @(negedge clk);
      check("len0_idle", int'(busy), 0);
      check("len0_nodone", int'(done), 0);
      check("len0_pulses", done_n - dn0, 1);
      @(posedge clk); #1;

      // bubbles plus an ignored start mid-frame
      dn0 = done_n;
      smp[0] = 9; smp[1] = 4; smp[2] = 12; smp[3] = 7;
      fork
         run_frame({4'd5, 4'd6, 4'd7}, 4, 1);
         begin
            repeat (4) @(posedge clk);
            #1; start = 1; len = 8'd9;
            @(posedge clk); #1; start = 0;
         end
      join
      wait_done(4);
      repeat (3) @(negedge clk);
      check("ign_still_idle", int'(busy), 0);
      check("ign_frames", done_n - dn0, 1);
      @(posedge clk); #1;

      // reset mid-stream with two buffered results
      rdy_mode = 0;
      @(posedge clk); #1;
      start = 1; len = 8'd5; k_in = 12'h321;
      @(posedge clk); #1; start = 0;
      s_valid = 1; s_data = 4'd7;
      begin
         int acc = 0;
         int g = 0;
         while (acc < 2 && g < 50) begin
            @(negedge clk);
            if (s_valid && s_ready) acc++;
            @(posedge clk); #1;
            g++;
         end
         s_valid = 0;
         check("rst_pre_acc", acc, 2);
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_pre_mvalid", int'(m_valid), 1);
      check("rst_pre_busy", int'(busy), 1);
      dn0 = done_n;
      @(posedge clk); #1;
      rst = 1;
      #1;
      check_reset_outs("rstmid");
      @(posedge clk); #1;
      q.delete();
      h0 = 0; h1 = 0; h2 = 0; last_data = 0;
      rst = 0;
      rdy_mode = 2;
      for (int i = 0; i < 7; i++)
         smp[i] = int'($urandom_range(0, 15));
      run_frame(12'(($urandom_range(0, 4095))), 7, 0);
      wait_done(7);
      check("rst_no_extra_done", done_n - dn0, 1);
      check("sb_drained", int'(q.size()), 0);

      $display("TB_RESULT checks=%0d failures=%0d",
               checks, failures);
      $finish;
   end
endmodule
